// File: rtl/prio_load_arbiter.sv
// -----------------------------------------------------------------------------
// prio_load_arbiter
//
// Single-clock controller for a W-bit state register that three prioritised
// event sources (A > B > C) and one data path (D) compete to load. A request
// seen while idle is granted with a one-cycle pulse on gnt. The matching
// constant is loaded into q at the same time. The block then ignores all
// inputs for one GRANT cycle plus HOLD hold cycles before it looks again.
// When idle with no request pending, d_en loads d directly.
//
// Requests are level-sensitive and never latched. A request that is not
// high in an IDLE cycle is simply not seen. Lower sources can be starved by
// a higher source that stays asserted.
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous, active-high reset
//   req   in   3   level requests: bit0 = A (highest), bit1 = B, bit2 = C
//   d     in   W   data-path value
//   d_en  in   1   load d when idle and no request is pending
//   gnt   out  3   one-hot grant, one cycle per grant, aligned with req
//   q     out  W   registered value
//   src   out  2   source of the last load: 0 = D/reset, 1 = A, 2 = B, 3 = C
//   busy  out  1   high while the controller is not IDLE
// -----------------------------------------------------------------------------
module prio_load_arbiter #(
  parameter int W     = 2,
  parameter int VAL_A = 2,
  parameter int VAL_B = 1,
  parameter int VAL_C = 0,
  parameter int HOLD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] d,
  input  logic         d_en,
  output logic [2:0]   gnt,
  output logic [W-1:0] q,
  output logic [1:0]   src,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Source codes, shared by src and the internal winner signal.
  localparam logic [1:0] SRC_D = 2'd0;
  localparam logic [1:0] SRC_A = 2'd1;
  localparam logic [1:0] SRC_B = 2'd2;
  localparam logic [1:0] SRC_C = 2'd3;

  // Load constants are taken modulo 2^W, so oversized values simply wrap.
  localparam logic [W-1:0] LOAD_A = W'(VAL_A);
  localparam logic [W-1:0] LOAD_B = W'(VAL_B);
  localparam logic [W-1:0] LOAD_C = W'(VAL_C);

  // The hold counter counts down to zero. Loading HOLD-1 gives exactly
  // HOLD cycles in ST_HOLD. HOLD = 0 bypasses ST_HOLD entirely.
  localparam bit         HAS_HOLD  = (HOLD > 0);
  localparam logic [3:0] HOLD_LOAD = HAS_HOLD ? 4'(HOLD - 1) : 4'd0;

  // Fixed priority: the lowest set request bit wins.
  function automatic logic [1:0] pick_src(input logic [2:0] r);
    logic [1:0] s;
    s = SRC_D;
    if (r[0])      s = SRC_A;
    else if (r[1]) s = SRC_B;
    else if (r[2]) s = SRC_C;
    return s;
  endfunction

  function automatic logic [W-1:0] load_val(input logic [1:0] s);
    logic [W-1:0] v;
    case (s)
      SRC_A:   v = LOAD_A;
      SRC_B:   v = LOAD_B;
      SRC_C:   v = LOAD_C;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Source code -> grant bit. Source x maps to req bit x-1.
  function automatic logic [2:0] src_onehot(input logic [1:0] s);
    logic [2:0] g;
    case (s)
      SRC_A:   g = 3'b001;
      SRC_B:   g = 3'b010;
      SRC_C:   g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] win_src;
  logic       any_req;

  always_comb begin
    win_src = pick_src(req);
    any_req = |req;
  end

  // All outputs are registered. busy is set from the next state, so it is
  // valid in the same cycle as gnt. No separate decode of state is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      gnt   <= 3'b000;
      q     <= '0;
      src   <= SRC_D;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gnt <= 3'b000;
          if (any_req) begin
            // A request beats d_en in the same cycle.
            q     <= load_val(win_src);
            src   <= win_src;
            gnt   <= src_onehot(win_src);
            state <= ST_GRANT;
            busy  <= 1'b1;
          end else if (d_en) begin
            q   <= d;
            src <= SRC_D;
          end
        end

        ST_GRANT: begin
          gnt <= 3'b000;
          if (HAS_HOLD) begin
            cnt   <= HOLD_LOAD;
            state <= ST_HOLD;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_HOLD: begin
          gnt <= 3'b000;
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
          gnt   <= 3'b000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_load_arbiter.sv
module tb_prio_load_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [1:0] d;
  logic       d_en;

  logic [2:0] gnt0, gnt2, gnt3;
  logic [1:0] q0, q2, q3;
  logic [1:0] src0, src2, src3;
  logic       busy0, busy2, busy3;

  int nchecks = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  // Three instances share the stimulus; each test resets and checks one.
  prio_load_arbiter #(.W(2), .VAL_A(2), .VAL_B(1), .VAL_C(0), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .d(d), .d_en(d_en),
    .gnt(gnt0), .q(q0), .src(src0), .busy(busy0));

  prio_load_arbiter #(.W(2), .VAL_A(2), .VAL_B(1), .VAL_C(0), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .d(d), .d_en(d_en),
    .gnt(gnt2), .q(q2), .src(src2), .busy(busy2));

  prio_load_arbiter #(.W(2), .VAL_A(2), .VAL_B(1), .VAL_C(0), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .d(d), .d_en(d_en),
    .gnt(gnt3), .q(q3), .src(src3), .busy(busy3));

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Grant rule, checked between edges on every instance:
  // one-hot or zero, and never high on two consecutive cycles.
  logic [2:0] pg0 = 3'b000, pg2 = 3'b000, pg3 = 3'b000;
  always @(negedge clk) begin
    nchecks++;
    assert ($onehot0(gnt0) && !(gnt0 != 3'b000 && pg0 != 3'b000) &&
            $onehot0(gnt2) && !(gnt2 != 3'b000 && pg2 != 3'b000) &&
            $onehot0(gnt3) && !(gnt3 != 3'b000 && pg3 != 3'b000))
    else begin
      nfail++;
      $display("FAIL gnt_rule: gnt0=%b/%b gnt2=%b/%b gnt3=%b/%b (now/prev), required one-hot-or-zero, no back-to-back",
               gnt0, pg0, gnt2, pg2, gnt3, pg3);
    end
    pg0 <= gnt0;
    pg2 <= gnt2;
    pg3 <= gnt3;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end, required finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [2:0] req;
    logic [1:0] d;
    logic       d_en;
    logic [2:0] e_gnt;
    logic [1:0] e_q;
    logic [1:0] e_src;
    logic       e_busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  // Leaves time at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    rst  = 1'b1;
    req  = 3'b000;
    d    = 2'd0;
    d_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // HOLD = 2 sequence, applied to dut2 (one row per clock edge).
    //                req     d    den  gnt     q    src  busy
    // simultaneous requests, A wins, period 4, B never served
    vec[0]  = '{3'b111, 2'd0, 1'b0, 3'b001, 2'd2, 2'd1, 1'b1};
    vec[1]  = '{3'b111, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[2]  = '{3'b111, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[3]  = '{3'b111, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b0};
    vec[4]  = '{3'b111, 2'd0, 1'b0, 3'b001, 2'd2, 2'd1, 1'b1};
    // d_en while busy is ignored
    vec[5]  = '{3'b000, 2'd3, 1'b1, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[6]  = '{3'b000, 2'd3, 1'b1, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[7]  = '{3'b000, 2'd3, 1'b1, 3'b000, 2'd2, 2'd1, 1'b0};
    // data load in IDLE
    vec[8]  = '{3'b000, 2'd3, 1'b1, 3'b000, 2'd3, 2'd0, 1'b0};
    // request beats d_en
    vec[9]  = '{3'b100, 2'd3, 1'b1, 3'b100, 2'd0, 2'd3, 1'b1};
    // d held through GRANT/HOLD, loaded once IDLE
    vec[10] = '{3'b000, 2'd1, 1'b1, 3'b000, 2'd0, 2'd3, 1'b1};
    vec[11] = '{3'b000, 2'd1, 1'b1, 3'b000, 2'd0, 2'd3, 1'b1};
    vec[12] = '{3'b000, 2'd1, 1'b1, 3'b000, 2'd0, 2'd3, 1'b0};
    vec[13] = '{3'b000, 2'd1, 1'b1, 3'b000, 2'd1, 2'd0, 1'b0};
    // short C pulse while busy is lost
    vec[14] = '{3'b001, 2'd0, 1'b0, 3'b001, 2'd2, 2'd1, 1'b1};
    vec[15] = '{3'b100, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[16] = '{3'b000, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b1};
    vec[17] = '{3'b000, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b0};
    vec[18] = '{3'b000, 2'd0, 1'b0, 3'b000, 2'd2, 2'd1, 1'b0};

    // ---- reset state ----
    rst  = 1'b1;
    req  = 3'b000;
    d    = 2'd0;
    d_en = 1'b0;
    #12;
    chk("rst_q",    int'(q2),    0);
    chk("rst_src",  int'(src2),  0);
    chk("rst_gnt",  int'(gnt2),  0);
    chk("rst_busy", int'(busy2), 0);
    do_reset();

    // ---- table-driven sequence on dut2 ----
    for (int i = 0; i < NV; i++) begin
      req  = vec[i].req;
      d    = vec[i].d;
      d_en = vec[i].d_en;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt", i),  int'(gnt2),  int'(vec[i].e_gnt));
      chk($sformatf("v%0d_q", i),    int'(q2),    int'(vec[i].e_q));
      chk($sformatf("v%0d_src", i),  int'(src2),  int'(vec[i].e_src));
      chk($sformatf("v%0d_busy", i), int'(busy2), int'(vec[i].e_busy));
    end

    // ---- priority hand-off, HOLD = 0 (dut0) ----
    do_reset();
    req = 3'b110;
    @(posedge clk);
    #1;
    chk("ho_gnt_b", int'(gnt0),  3'b010);
    chk("ho_q_b",   int'(q0),    1);
    chk("ho_src_b", int'(src0),  2);
    chk("ho_busy",  int'(busy0), 1);
    req = 3'b100;
    @(posedge clk);
    #1;
    chk("ho_gnt_off",  int'(gnt0),  0);
    chk("ho_busy_off", int'(busy0), 0);
    chk("ho_q_hold",   int'(q0),    1);
    @(posedge clk);
    #1;
    chk("ho_gnt_c", int'(gnt0), 3'b100);
    chk("ho_q_c",   int'(q0),   0);
    chk("ho_src_c", int'(src0), 3);

    // ---- reset mid-HOLD, HOLD = 3 (dut3) ----
    do_reset();
    req = 3'b001;
    @(posedge clk);
    #1;
    chk("rh_gnt_a", int'(gnt3), 3'b001);
    chk("rh_q_a",   int'(q3),   2);
    @(posedge clk);   // first HOLD cycle
    @(posedge clk);   // second HOLD cycle
    #1;
    chk("rh_busy_hold", int'(busy3), 1);
    chk("rh_gnt_hold",  int'(gnt3),  0);
    #2;
    rst = 1'b1;
    #1;
    chk("rh_q_rst",    int'(q3),    0);
    chk("rh_src_rst",  int'(src3),  0);
    chk("rh_busy_rst", int'(busy3), 0);
    chk("rh_gnt_rst",  int'(gnt3),  0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rh_regnt",     int'(gnt3),  3'b001);
    chk("rh_regnt_q",   int'(q3),    2);
    chk("rh_regnt_src", int'(src3),  1);
    chk("rh_regnt_bsy", int'(busy3), 1);
    req = 3'b000;
    repeat (6) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", nchecks - nfail, nchecks);
    $finish;
  end

endmodule
